// File: rtl/mic_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mic_fifo_pkg
//  Description : Shared types and constants for the microphone sample FIFO:
//                stereo frame layout, Avalon register addresses and the
//                STATUS / CTRL bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package mic_fifo_pkg;

    // One captured frame from both microphone sets; packs as {l1, r1, l2, r2}
    typedef struct packed {
        logic [23:0] left1;
        logic [23:0] right1;
        logic [23:0] left2;
        logic [23:0] right2;
    } frame_t;

    // Avalon word addresses
    localparam logic [2:0] ADDR_L1     = 3'd0;
    localparam logic [2:0] ADDR_R1     = 3'd1;
    localparam logic [2:0] ADDR_L2     = 3'd2;
    localparam logic [2:0] ADDR_R2     = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_POP    = 3'd5;
    localparam logic [2:0] ADDR_CTRL   = 3'd6;
    localparam logic [2:0] ADDR_FLUSH  = 3'd7;

    // STATUS bit positions (count occupies [8:0])
    localparam int STAT_EMPTY = 9;
    localparam int STAT_FULL  = 10;
    localparam int STAT_OVF   = 11;
    localparam int STAT_IRQ   = 12;

    // CTRL bit positions (watermark occupies [7:0])
    localparam int CTRL_IRQ_EN  = 8;
    localparam int CTRL_OVF_CLR = 9;

    // Sign-extend a 24-bit two's complement sample to a 32-bit bus word
    function automatic logic [31:0] sext24(input logic [23:0] v);
        return {{8{v[23]}}, v};
    endfunction

endpackage : mic_fifo_pkg
`default_nettype wire

// File: rtl/sync_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_frame_fifo
//  Description : Single-clock frame FIFO with show-ahead head output, flush,
//                and push-while-full acceptance when a pop frees a slot in
//                the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_frame_fifo
    import mic_fifo_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  frame_t        i_data,
    output frame_t        o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    frame_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop frees a slot, so a push while full is accepted in that cycle
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy tracking; flush overrides both push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Frame storage; the whole frame is written in one cycle, never partially
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule : sync_frame_fifo
`default_nettype wire

// File: rtl/mic_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mic_sample_fifo
//  Description : Buffers completed I2S microphone frames in a FIFO and
//                exposes them to the HPS through an Avalon-MM slave with a
//                watermark-level interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module mic_sample_fifo
    import mic_fifo_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [23:0] in_left1,
    input  logic [23:0] in_right1,
    input  logic [23:0] in_left2,
    input  logic [23:0] in_right2,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    frame_t      w_frame;
    frame_t      w_head;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [8:0]  w_count9;
    logic        w_rd;
    logic        w_wr;
    logic        w_pop;
    logic        w_flush;
    logic        w_ctrl_wr;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    logic [7:0]  r_watermark;
    logic        r_irq_en;
    logic        r_overflow;
    logic        r_irq;
    logic [31:0] r_readdata;

    assign w_frame   = '{left1: in_left1, right1: in_right1,
                         left2: in_left2, right2: in_right2};
    assign w_rd      = chipselect && read;
    assign w_wr      = chipselect && write;
    assign w_pop     = w_rd && (address == ADDR_POP);
    assign w_flush   = w_wr && (address == ADDR_FLUSH);
    assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);
    assign w_ovf_clr = w_ctrl_wr && writedata[CTRL_OVF_CLR];
    // A frame is lost only when full and no pop makes room; a flush discards
    // the frame for its own reason and does not count as an overflow
    assign w_ovf_set = in_valid && w_full && !w_pop && !w_flush;
    assign w_count9  = 9'(w_count);
    assign w_unused_wdata = ^writedata[31:10];

    sync_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_frame),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Control register; a zero watermark would make irq permanently true
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_watermark <= 8'd1;
            r_irq_en    <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_watermark <= (writedata[7:0] == 8'd0) ? 8'd1 : writedata[7:0];
            r_irq_en    <= writedata[CTRL_IRQ_EN];
        end
    end

    // Sticky overflow; software clear wins over a coincident drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_overflow <= 1'b0;
        else if (w_ovf_clr) r_overflow <= 1'b0;
        else if (w_ovf_set) r_overflow <= 1'b1;
    end

    // Registered level interrupt on occupancy reaching the watermark
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= r_irq_en && (w_count9 >= {1'b0, r_watermark});
    end

    // STATUS word assembly
    always_comb begin
        w_status             = '0;
        w_status[8:0]        = w_count9;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_OVF]   = r_overflow;
        w_status[STAT_IRQ]   = r_irq;
    end

    // Read mux; head-frame fields read as zero while the FIFO is empty
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_L1:     w_rdata = w_empty ? 32'd0 : sext24(w_head.left1);
            ADDR_R1:     w_rdata = w_empty ? 32'd0 : sext24(w_head.right1);
            ADDR_L2:     w_rdata = w_empty ? 32'd0 : sext24(w_head.left2);
            ADDR_R2:     w_rdata = w_empty ? 32'd0 : sext24(w_head.right2);
            ADDR_STATUS: w_rdata = w_status;
            ADDR_POP:    w_rdata = {31'd0, !w_empty};
            ADDR_CTRL:   w_rdata = {23'd0, r_irq_en, r_watermark};
            default:     w_rdata = '0;
        endcase
    end

    // Read-latency-1 data register; holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_readdata <= '0;
        else if (w_rd) r_readdata <= w_rdata;
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule : mic_sample_fifo
`default_nettype wire

// File: tb/tb_mic_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mic_sample_fifo
//  Description : Self-checking bench for mic_sample_fifo: table of frame
//                vectors with hand-derived bus words, plus a frame queue
//                model for fill, overflow, irq, flush and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mic_sample_fifo;
    import mic_fifo_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_left1 = '0, in_right1 = '0, in_left2 = '0, in_right2 = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    mic_sample_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_left1   (in_left1),
        .in_right1  (in_right1),
        .in_left2   (in_left2),
        .in_right2  (in_right2),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        frame_t            f;
        logic [3:0][31:0]  exp;
    } vec_t;

    vec_t   vecs [3];
    frame_t sb [$];
    int     n_checks = 0;
    int     n_errors = 0;
    logic   m_ovf = 1'b0;
    logic   m_irq_en = 1'b0;
    logic [7:0] m_wm = 8'd1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h expected=%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = sb.size();
        s = '0;
        s[8:0]        = 9'(n);
        s[STAT_EMPTY] = (n == 0);
        s[STAT_FULL]  = (n == DEPTH);
        s[STAT_OVF]   = m_ovf;
        s[STAT_IRQ]   = m_irq_en && (n >= int'(m_wm));
        return s;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.left1  = 24'($urandom);
        f.right1 = 24'($urandom);
        f.left2  = 24'($urandom);
        f.right2 = 24'($urandom);
        return f;
    endfunction

    task automatic drive_frame(input frame_t f);
        in_left1 = f.left1; in_right1 = f.right1;
        in_left2 = f.left2; in_right2 = f.right2;
    endtask

    task automatic push_frame(input frame_t f);
        @(posedge clk); #1;
        in_valid = 1'b1;
        drive_frame(f);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (sb.size() < DEPTH) sb.push_back(f);
        else m_ovf = 1'b1;
    endtask

    task automatic avl_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic avl_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
        if (a == ADDR_CTRL) begin
            m_wm     = (d[7:0] == 8'd0) ? 8'd1 : d[7:0];
            m_irq_en = d[CTRL_IRQ_EN];
            if (d[CTRL_OVF_CLR]) m_ovf = 1'b0;
        end else if (a == ADDR_FLUSH) begin
            sb.delete();
        end
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        avl_read(ADDR_STATUS, d);
        check(name, d, model_status());
    endtask

    task automatic check_head(input string name);
        logic [31:0] d;
        avl_read(ADDR_L1, d);
        check({name, "_l1"}, d, (sb.size() == 0) ? 32'd0 : sext24(sb[0].left1));
        avl_read(ADDR_R2, d);
        check({name, "_r2"}, d, (sb.size() == 0) ? 32'd0 : sext24(sb[0].right2));
    endtask

    task automatic pop_check(input string name);
        logic [31:0] d;
        avl_read(ADDR_POP, d);
        check(name, d, {31'd0, sb.size() != 0});
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        frame_t f;

        // Vectors: frame fields and the hand-derived sign-extended bus words
        vecs[0].f   = '{left1: 24'h800001, right1: 24'h000005, left2: 24'h7FFFFF, right2: 24'h000000};
        vecs[0].exp = {32'h00000000, 32'h007FFFFF, 32'h00000005, 32'hFF800001};
        vecs[1].f   = '{left1: 24'hFFFFFF, right1: 24'h800000, left2: 24'h000001, right2: 24'h123456};
        vecs[1].exp = {32'h00123456, 32'h00000001, 32'hFF800000, 32'hFFFFFFFF};
        vecs[2].f   = '{left1: 24'h400000, right1: 24'hC00000, left2: 24'h7FFFFE, right2: 24'h800001};
        vecs[2].exp = {32'hFF800001, 32'h007FFFFE, 32'hFFC00000, 32'h00400000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        avl_read(ADDR_STATUS, d);  check("rst_status", d, 32'h00000200);
        avl_read(ADDR_POP, d);     check("rst_pop_empty", d, 32'd0);
        avl_read(ADDR_L1, d);      check("rst_head_empty", d, 32'd0);
        avl_read(ADDR_FLUSH, d);   check("rd_addr7", d, 32'd0);
        avl_read(ADDR_CTRL, d);    check("rst_ctrl", d, 32'h00000001);

        // Table-driven frame vectors
        for (int i = 0; i < 3; i++) begin
            push_frame(vecs[i].f);
            for (int a = 0; a < 4; a++) begin
                avl_read(3'(a), d);
                check($sformatf("vec%0d_addr%0d", i, a), d, vecs[i].exp[a]);
            end
            pop_check($sformatf("vec%0d_pop", i));
            check_status($sformatf("vec%0d_status", i));
        end

        // Writes to read-only addresses are ignored
        avl_write(ADDR_STATUS, 32'hFFFFFFFF);
        avl_write(ADDR_POP, 32'hFFFFFFFF);
        check_status("ro_write_status");

        // Fill past capacity: the extra frame is dropped and overflow sticks
        for (int i = 0; i < DEPTH + 1; i++) push_frame(rand_frame());
        check_status("full_ovf_status");
        check_head("full_head");
        avl_write(ADDR_CTRL, 32'h00000200);
        check_status("ovf_cleared");
        avl_read(ADDR_CTRL, d);
        check("ctrl_wm_zero", d, 32'h00000001);

        // Push coinciding with a pop while full
        f = rand_frame();
        @(posedge clk); #1;
        in_valid = 1'b1; drive_frame(f);
        chipselect = 1'b1; read = 1'b1; address = ADDR_POP;
        @(posedge clk); #1;
        in_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
        check("full_push_pop", readdata, 32'd1);
        void'(sb.pop_front());
        sb.push_back(f);
        check_status("full_push_pop_status");

        // Drain, checking every head against the queue
        for (int i = 0; i < DEPTH; i++) begin
            check_head($sformatf("drain%0d", i));
            pop_check($sformatf("drain%0d_pop", i));
        end
        check_status("drained_status");
        pop_check("drained_pop");

        // Watermark interrupt
        avl_write(ADDR_CTRL, 32'h00000104);
        for (int i = 0; i < 3; i++) push_frame(rand_frame());
        check("irq_below_wm", {31'd0, irq}, 32'd0);
        push_frame(rand_frame());
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_at_wm", {31'd0, irq}, 32'd1);
        check_status("irq_status");
        pop_check("irq_pop");
        @(posedge clk); #1;
        check("irq_after_pop", {31'd0, irq}, 32'd0);

        // Flush wins over a coincident push
        avl_write(ADDR_FLUSH, 32'd0);
        for (int i = 0; i < 5; i++) push_frame(rand_frame());
        check_status("pre_flush_status");
        @(posedge clk); #1;
        in_valid = 1'b1; drive_frame(rand_frame());
        chipselect = 1'b1; write = 1'b1; address = ADDR_FLUSH;
        @(posedge clk); #1;
        in_valid = 1'b0; chipselect = 1'b0; write = 1'b0;
        sb.delete();
        check_status("flush_status");
        check_head("flush_head");

        // Asynchronous reset in the middle of a push
        avl_write(ADDR_CTRL, 32'h00000101);
        push_frame(rand_frame());
        push_frame(rand_frame());
        @(posedge clk); #1;
        check("irq_before_reset", {31'd0, irq}, 32'd1);
        check_status("status_before_reset");
        @(posedge clk); #1;
        in_valid = 1'b1; drive_frame(rand_frame());
        #4 reset = 1'b1;
        #1;
        check("reset_irq_async", {31'd0, irq}, 32'd0);
        check("reset_readdata_async", readdata, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        sb.delete(); m_ovf = 1'b0; m_irq_en = 1'b0; m_wm = 8'd1;
        check_status("post_reset_status");
        avl_read(ADDR_CTRL, d);
        check("post_reset_ctrl", d, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mic_sample_fifo
`default_nettype wire

// File: doc/mic_sample_fifo.md
Name: mic_sample_fifo

Overview:
- Downstream stage of the I2S microphone decoder.
- Captures each completed stereo frame from both microphone sets (left1, right1, left2, right2; 24-bit each) into a frame FIFO.
- Exposes the FIFO to the HPS over an Avalon-MM slave, with a watermark interrupt.
- Decouples HPS read jitter from the fixed audio sample rate; replaces the single-frame, overwrite-prone readout path.

Parameters:
- DEPTH, 64, number of frames stored; power of two, 4..256.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-clk pulse: frame on in_* is complete. Already synchronized to clk by the decoder.
- in_left1  in  24  mic set 1 left sample, two's complement.
- in_right1  in  24  mic set 1 right sample.
- in_left2  in  24  mic set 2 left sample.
- in_right2  in  24  mic set 2 right sample.
- chipselect  in  1  Avalon select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  3  Avalon word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; read latency 1.
- irq  out  1  level interrupt to HPS.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; count=0; overflow=0.
  - ctrl: watermark=1, irq_en=0.
  - readdata=0; irq=0.
- Frame word: 96 bits, {left1, right1, left2, right2}.
- Push: on in_valid=1.
  - If not full, write the frame at wr_ptr; wr_ptr++ (wraps modulo DEPTH).
  - If full and no pop in the same cycle, drop the frame and set sticky overflow=1.
  - If full and a pop occurs in the same cycle, accept the frame; count unchanged.
- Pop: a read of address 5 advances rd_ptr when the FIFO is not empty.
  - readdata=1 if a frame was popped, 0 if the FIFO was empty (no pointer change).
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect; count unchanged.
- count ranges 0..DEPTH (AW+1 bits); full = (count==DEPTH); empty = (count==0).
- Register map (reads registered, one clk after chipselect&read):
  - 0..3: head frame left1/right1/left2/right2, sign-extended to 32 bits. Reads have no side effect and return 0 when empty.
  - 4 STATUS (read): [8:0] count, [9] empty, [10] full, [11] overflow, [12] irq.
  - 5 POP (read): as above.
  - 6 CTRL (read/write):
    - [7:0] watermark; a write of 0 is stored as 1.
    - [8] irq_en.
    - [9] write-1 clears overflow; always reads 0.
  - 7 FLUSH (write): any write empties the FIFO; rd_ptr=wr_ptr=0. Overflow is not cleared.
- Precedence:
  - Flush beats push in the same cycle (frame discarded).
  - Overflow clear beats overflow set in the same cycle.
- Writes to addresses 0..5 are ignored. Reads of address 7 return 0.
- readdata holds its last value when there is no read.
- irq is registered: irq <= irq_en && (count >= watermark). It deasserts the clk after count drops below watermark or irq_en is cleared.
- Reset mid-operation: all state returns to reset values immediately. Frames in flight are lost; no partial frame is ever stored.

Decomposition:
- Package mic_fifo_pkg holds:
  - typedef frame_t (packed struct of four logic [23:0] fields).
  - Address constants ADDR_L1, ADDR_R1, ADDR_L2, ADDR_R2, ADDR_STATUS, ADDR_POP, ADDR_CTRL, ADDR_FLUSH.
  - STATUS/CTRL bit-index constants.
- One sub-module, sync_frame_fifo: generic single-clock FIFO of frame_t with push, pop, flush, full, empty, count and show-ahead head output.
- The Avalon register decode and irq logic live in the top level.

Test Plan:
- Reset, then read STATUS -> readdata=0x200 (count 0, empty). Read POP -> 0. Read address 0 -> 0.
- Push frame L1=0x800001, R1=0x000005, L2=0x7FFFFF, R2=0x000000:
  - Read 0 -> 0xFF800001; read 1 -> 0x00000005; read 2 -> 0x007FFFFF.
  - Then POP -> 1; STATUS count=0.
- Push DEPTH+1 frames (64+1) -> STATUS=0x0C40 (count 64, full, overflow). The head is frame 0 and the 65th frame is absent.
  - Write CTRL bit 9 -> overflow=0.
- Write CTRL=0x104 (watermark 4, irq_en); push 3 frames -> irq=0. 4th push -> irq=1 one clk later. One POP -> irq=0.
- With count=64, assert in_valid on the same clk as a POP read -> count stays 64, overflow stays 0, the new frame lands last.
- Push 5 frames, then write FLUSH in the same cycle as in_valid -> count=0, empty=1. Assert reset mid-push -> irq=0 and count=0 immediately (asynchronous).
